// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, op/size codes, FSM states and bus helpers for the memory-access stage.
// Contents: datapath widths (ADDR_W, INSTR_W, WORD_W, DEST_SRC_W, REG_IDX_W), MEM_OP_* and
// MEM_SIZE_* codes, DEST_SRC_NONE, the stage FSM state type and helpers for byte enables,
// store-lane replication and alignment checks.
package mem_access_pkg;

    localparam int ADDR_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int WORD_W     = 32;
    localparam int DEST_SRC_W = 2;
    localparam int REG_IDX_W  = 5;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [1:0] op);
        return op == MEM_OP_LOAD || op == MEM_OP_STORE;
    endfunction

    // Only the low address bits that the access size forbids count as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == MEM_SIZE_H && a[0]) || (size == MEM_SIZE_W && a != 2'b00);
    endfunction

    // Halfwords use a[1] only and words ignore a[1:0], so unaligned addresses degrade
    // to the enclosing aligned lane group.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        return size == MEM_SIZE_B ? 4'b0001 << a :
               size == MEM_SIZE_H ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction

    function automatic logic [WORD_W-1:0] store_lanes(input logic [1:0] size, input logic [WORD_W-1:0] d);
        return size == MEM_SIZE_B ? {4{d[7:0]}} :
               size == MEM_SIZE_H ? {2{d[15:0]}} : d;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: combinational load-data aligner; shifts the addressed byte/half down and extends it.
// Ports: rdata (raw bus word), a (address low bits), size (MEM_SIZE_*), is_unsigned
// (zero-extend when 1), data (aligned, extended word).
module load_align
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        a,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] data
);

    logic [WORD_W-1:0] sh;

    always_comb begin
        sh   = size == MEM_SIZE_B ? rdata >> {a, 3'b000} :
               size == MEM_SIZE_H ? rdata >> {a[1], 4'b0000} : rdata;
        data = size == MEM_SIZE_B ? {{(WORD_W-8){~is_unsigned & sh[7]}}, sh[7:0]} :
               size == MEM_SIZE_H ? {{(WORD_W-16){~is_unsigned & sh[15]}}, sh[15:0]} : sh;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage; registers execute results and runs the data-bus handshake.
// Ports: clk, clr_n (sync active-low reset), i_stall (hazard hold), i_pc/i_instr/i_dest_src/
// i_dest_reg/i_alu_eval/i_store_data/i_mem_op/i_mem_size/i_mem_unsigned (from execute),
// o_pc/o_instr/o_dest_src/o_dest_reg/o_alu_eval/o_mem_read (to me), o_stall (access outstanding),
// o_bus_req/o_bus_we/o_bus_addr/o_bus_wdata/o_bus_be, i_bus_ack/i_bus_rdata (data bus),
// o_misalign (misaligned-access flag).
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  i_stall,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic [DEST_SRC_W-1:0] i_dest_src,
    input  logic [REG_IDX_W-1:0]  i_dest_reg,
    input  logic [WORD_W-1:0]     i_alu_eval,
    input  logic [WORD_W-1:0]     i_store_data,
    input  logic [1:0]            i_mem_op,
    input  logic [1:0]            i_mem_size,
    input  logic                  i_mem_unsigned,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [DEST_SRC_W-1:0] o_dest_src,
    output logic [REG_IDX_W-1:0]  o_dest_reg,
    output logic [WORD_W-1:0]     o_alu_eval,
    output logic [WORD_W-1:0]     o_mem_read,
    output logic                  o_stall,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [WORD_W-1:0]     o_bus_wdata,
    output logic [3:0]            o_bus_be,
    input  logic                  i_bus_ack,
    input  logic [WORD_W-1:0]     i_bus_rdata,
    output logic                  o_misalign
);

    state_t                state, state_nx;
    logic [ADDR_W-1:0]     r_pc;
    logic [INSTR_W-1:0]    r_instr;
    logic [DEST_SRC_W-1:0] r_dest_src;
    logic [REG_IDX_W-1:0]  r_dest_reg;
    logic [WORD_W-1:0]     r_alu_eval;
    logic [WORD_W-1:0]     r_store_data;
    logic [1:0]            r_mem_op;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [WORD_W-1:0]     r_rdata;
    logic [WORD_W-1:0]     load_word;
    logic                  load_en;
    logic                  in_mis;
    logic                  r_mis;
    logic                  in_go;

`ifdef MISALIGN_TRAP_EN
    assign in_mis = is_mem_op(i_mem_op) && misaligned(i_mem_size, i_alu_eval[1:0]);
    assign r_mis  = is_mem_op(r_mem_op) && misaligned(r_size, r_alu_eval[1:0]);
`else
    assign in_mis = 1'b0;
    assign r_mis  = 1'b0;
`endif

    assign load_en = !i_stall && !o_stall;
    assign in_go   = is_mem_op(i_mem_op) && !in_mis;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state        <= ST_IDLE;
            r_pc         <= '0;
            r_instr      <= '0;
            r_dest_src   <= '0;
            r_dest_reg   <= '0;
            r_alu_eval   <= '0;
            r_store_data <= '0;
            r_mem_op     <= MEM_OP_NONE;
            r_size       <= MEM_SIZE_B;
            r_unsigned   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            state <= state_nx;
            if (load_en) begin
                r_pc         <= i_pc;
                r_instr      <= i_instr;
                r_dest_src   <= i_dest_src;
                r_dest_reg   <= i_dest_reg;
                r_alu_eval   <= i_alu_eval;
                r_store_data <= i_store_data;
                r_mem_op     <= i_mem_op;
                r_size       <= i_mem_size;
                r_unsigned   <= i_mem_unsigned;
            end
            if (state == ST_BUSY && i_bus_ack)
                r_rdata <= i_bus_rdata;
        end
    end

    // BUSY ignores i_stall; DONE/IDLE advance only when the stage actually loads.
    always_comb begin
        state_nx = state;
        state_nx = state == ST_BUSY ? (i_bus_ack ? ST_DONE : ST_BUSY) :
                   load_en          ? (in_go ? ST_BUSY : ST_IDLE) : state;
    end

    load_align u_load_align (
        .rdata       (r_rdata),
        .a           (r_alu_eval[1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .data        (load_word)
    );

    // be/we are gated by the request so the idle bus shows no lanes and no write.
    always_comb begin
        o_stall     = state == ST_BUSY;
        o_bus_req   = state == ST_BUSY;
        o_bus_we    = o_bus_req && r_mem_op == MEM_OP_STORE;
        o_bus_addr  = {r_alu_eval[ADDR_W-1:2], 2'b00};
        o_bus_wdata = store_lanes(r_size, r_store_data);
        o_bus_be    = o_bus_req ? byte_en(r_size, r_alu_eval[1:0]) : 4'b0000;
        o_pc        = r_pc;
        o_instr     = r_instr;
        o_dest_src  = r_mis ? DEST_SRC_NONE : r_dest_src;
        o_dest_reg  = r_dest_reg;
        o_alu_eval  = r_alu_eval;
        o_mem_read  = r_mem_op == MEM_OP_LOAD && !r_mis ? load_word : '0;
        o_misalign  = r_mis;
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access; directed loads/stores, wait states, resets, misalignment.
module tb_mem_access;
    import mem_access_pkg::*;

    logic                  clk = 1'b0;
    logic                  clr_n;
    logic                  i_stall;
    logic [ADDR_W-1:0]     i_pc;
    logic [INSTR_W-1:0]    i_instr;
    logic [DEST_SRC_W-1:0] i_dest_src;
    logic [REG_IDX_W-1:0]  i_dest_reg;
    logic [WORD_W-1:0]     i_alu_eval;
    logic [WORD_W-1:0]     i_store_data;
    logic [1:0]            i_mem_op;
    logic [1:0]            i_mem_size;
    logic                  i_mem_unsigned;
    logic [ADDR_W-1:0]     o_pc;
    logic [INSTR_W-1:0]    o_instr;
    logic [DEST_SRC_W-1:0] o_dest_src;
    logic [REG_IDX_W-1:0]  o_dest_reg;
    logic [WORD_W-1:0]     o_alu_eval;
    logic [WORD_W-1:0]     o_mem_read;
    logic                  o_stall;
    logic                  o_bus_req;
    logic                  o_bus_we;
    logic [ADDR_W-1:0]     o_bus_addr;
    logic [WORD_W-1:0]     o_bus_wdata;
    logic [3:0]            o_bus_be;
    logic                  i_bus_ack;
    logic [WORD_W-1:0]     i_bus_rdata;
    logic                  o_misalign;

    mem_access dut (
        .clk(clk), .clr_n(clr_n), .i_stall(i_stall), .i_pc(i_pc), .i_instr(i_instr),
        .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg), .i_alu_eval(i_alu_eval),
        .i_store_data(i_store_data), .i_mem_op(i_mem_op), .i_mem_size(i_mem_size),
        .i_mem_unsigned(i_mem_unsigned), .o_pc(o_pc), .o_instr(o_instr),
        .o_dest_src(o_dest_src), .o_dest_reg(o_dest_reg), .o_alu_eval(o_alu_eval),
        .o_mem_read(o_mem_read), .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          checks = 0;
    int          failures = 0;
    int          stall_cycles = 0;
    int          req_cycles = 0;
    logic        chk_done = 1'b0;
    logic [31:0] pc_ctr = 32'h100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: bus fields checked at the ack cycle, writeback data one cycle later in DONE.
    always @(negedge clk) begin
        if (chk_done) begin
            check("done_mem_read", o_mem_read, cur.rd);
            check("done_pc", o_pc, cur.pc);
            check("done_stall", {31'b0, o_stall}, 32'd0);
            chk_done <= 1'b0;
        end
        if (o_stall) stall_cycles++;
        if (o_bus_req) req_cycles++;
        if (o_bus_req && i_bus_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_req", {31'b0, o_bus_req}, 32'd0);
            end else begin
                cur = sb.pop_front();
                check("bus_addr", o_bus_addr, cur.addr);
                check("bus_be", {28'b0, o_bus_be}, {28'b0, cur.be});
                check("bus_we", {31'b0, o_bus_we}, {31'b0, cur.we});
                check("bus_wdata", o_bus_wdata, cur.wdata);
                chk_done <= 1'b1;
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata);
        pc_ctr         = pc_ctr + 4;
        i_pc           = pc_ctr;
        i_instr        = pc_ctr ^ 32'h13;
        i_dest_src     = 2'd1;
        i_dest_reg     = pc_ctr[6:2];
        i_alu_eval     = addr;
        i_store_data   = sdata;
        i_mem_op       = op;
        i_mem_size     = size;
        i_mem_unsigned = uns;
    endtask

    task automatic bubble();
        i_pc       = 32'hDEAD_0000;
        i_mem_op   = MEM_OP_NONE;
        i_alu_eval = 32'hFFFF_FFFF;
    endtask

    // Called just after a rising edge; returns just after the ack edge (plus hold cycles).
    task automatic do_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                         input int dly, input int hold, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata, input logic [31:0] e_rd);
        int s0, r0;
        drive(op, size, uns, addr, sdata);
        sb.push_back('{addr: e_addr, be: e_be, we: op == MEM_OP_STORE, wdata: e_wdata, rd: e_rd, pc: pc_ctr});
        s0 = stall_cycles;
        r0 = req_cycles;
        @(posedge clk) #1;
        bubble();
        if (hold > 0) i_stall = 1'b1;
        repeat (dly) @(posedge clk) #1;
        i_bus_ack   = 1'b1;
        i_bus_rdata = rdata;
        @(posedge clk) #1;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'hA5A5_A5A5;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_pc", o_pc, pc_ctr);
            check("hold_no_req", {31'b0, o_bus_req}, 32'd0);
            @(posedge clk) #1;
        end
        i_stall = 1'b0;
        check("stall_cycles", stall_cycles - s0, dly + 1);
        check("req_cycles", req_cycles - r0, dly + 1);
    endtask

    initial begin
        clr_n = 1'b0; i_stall = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = '0;
        drive(MEM_OP_LOAD, MEM_SIZE_W, 1'b0, 32'h1000, 32'h0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req", {31'b0, o_bus_req}, 32'd0);
            check("rst_stall", {31'b0, o_stall}, 32'd0);
            check("rst_misalign", {31'b0, o_misalign}, 32'd0);
            check("rst_mem_read", o_mem_read, 32'd0);
            check("rst_pc", o_pc, 32'd0);
            check("rst_be", {28'b0, o_bus_be}, 32'd0);
            check("rst_addr", o_bus_addr, 32'd0);
        end
        @(posedge clk) #1;
        clr_n = 1'b1;
        bubble();
        @(posedge clk) #1;

        // Non-memory op: one cycle, no stall.
        drive(MEM_OP_NONE, MEM_SIZE_W, 1'b0, 32'h77, 32'h0);
        @(posedge clk) #1;
        bubble();
        @(negedge clk);
        check("nop_stall", {31'b0, o_stall}, 32'd0);
        check("nop_alu", o_alu_eval, 32'h77);
        check("nop_mem_read", o_mem_read, 32'd0);
        check("nop_pc", o_pc, pc_ctr);
        @(posedge clk) #1;

        do_op(MEM_OP_LOAD, MEM_SIZE_B, 1'b0, 32'h1003, 32'h0, 32'h80FF_FF00, 0, 0, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_op(MEM_OP_STORE, MEM_SIZE_H, 1'b0, 32'h2002, 32'hABCD_1234, 32'h0, 0, 0, 32'h2000, 4'b1100, 32'h1234_1234, 32'h0);
        do_op(MEM_OP_LOAD, MEM_SIZE_B, 1'b1, 32'h1001, 32'h0, 32'h1234_5678, 1, 0, 32'h1000, 4'b0010, 32'h0, 32'h0000_0056);
        do_op(MEM_OP_LOAD, MEM_SIZE_H, 1'b0, 32'h1002, 32'h0, 32'h8001_0000, 0, 0, 32'h1000, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_op(MEM_OP_LOAD, MEM_SIZE_H, 1'b1, 32'h1002, 32'h0, 32'h8001_0000, 0, 0, 32'h1000, 4'b1100, 32'h0, 32'h0000_8001);
        do_op(MEM_OP_STORE, MEM_SIZE_B, 1'b0, 32'h13, 32'hFFFF_FFA5, 32'h0, 2, 0, 32'h10, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        do_op(MEM_OP_STORE, MEM_SIZE_W, 1'b0, 32'h24, 32'h1122_3344, 32'h0, 0, 0, 32'h24, 4'b1111, 32'h1122_3344, 32'h0);
        do_op(MEM_OP_LOAD, MEM_SIZE_W, 1'b0, 32'h5000, 32'h0, 32'hDEAD_BEEF, 3, 2, 32'h5000, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        bubble();
        @(posedge clk) #1;

`ifdef MISALIGN_TRAP_EN
        drive(MEM_OP_LOAD, MEM_SIZE_W, 1'b0, 32'h3001, 32'h0);
        @(posedge clk) #1;
        bubble();
        @(negedge clk);
        check("mis_flag", {31'b0, o_misalign}, 32'd1);
        check("mis_req", {31'b0, o_bus_req}, 32'd0);
        check("mis_stall", {31'b0, o_stall}, 32'd0);
        check("mis_dest_src", {30'b0, o_dest_src}, 32'd0);
        @(posedge clk) #1;
        @(negedge clk);
        check("mis_clear", {31'b0, o_misalign}, 32'd0);
        @(posedge clk) #1;
`else
        do_op(MEM_OP_LOAD, MEM_SIZE_W, 1'b0, 32'h3001, 32'h0, 32'h1357_9BDF, 0, 0, 32'h3000, 4'b1111, 32'h0, 32'h1357_9BDF);
        bubble();
        @(posedge clk) #1;
        check("mis_flag_off", {31'b0, o_misalign}, 32'd0);
`endif

        // Reset in the second BUSY cycle; a late ack must be ignored.
        drive(MEM_OP_LOAD, MEM_SIZE_W, 1'b0, 32'h4000, 32'h0);
        @(posedge clk) #1;
        bubble();
        @(negedge clk);
        check("midrst_req_before", {31'b0, o_bus_req}, 32'd1);
        @(posedge clk) #1;
        clr_n = 1'b0;
        @(posedge clk) #1;
        clr_n       = 1'b1;
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("midrst_req_after", {31'b0, o_bus_req}, 32'd0);
        check("midrst_stall_after", {31'b0, o_stall}, 32'd0);
        @(posedge clk) #1;
        i_bus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", {31'b0, o_bus_req}, 32'd0);
        check("late_ack_mem_read", o_mem_read, 32'd0);
        @(posedge clk) #1;

        do_op(MEM_OP_LOAD, MEM_SIZE_B, 1'b1, 32'h6002, 32'h0, 32'h00C3_0000, 0, 0, 32'h6000, 4'b0100, 32'h0, 32'h0000_00C3);
        bubble();
        repeat (2) @(posedge clk) #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
